bluetooth_rx: RTL



---
 rtl/bluetooth_rx_pkg.sv | 16 +
 rtl/bluetooth_rx_if.sv | 24 ++
 rtl/bluetooth_rx_sync.sv | 45 ++++
 rtl/bluetooth_rx.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bluetooth_rx_pkg.sv
// Shared Bluetooth link definitions: receiver state encoding and framing
// constants used by both the transmit and receive stages.
package bt_pkg;

    localparam int BT_BAUD_DIV_9600 = 5208;
    localparam int BT_FRAME_BITS    = 10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } bt_rx_state_t;

endpackage

// File: rtl/bluetooth_rx_if.sv
// Parallel output side of the Bluetooth receiver: received byte, strobes
// and busy flag. The receiver drives through the master modport.
interface bluetooth_rx_if;

    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    modport master (
        output data,
        output valid,
        output frame_err,
        output busy
    );

    modport slave (
        input data,
        input valid,
        input frame_err,
        input busy
    );

endinterface

// File: rtl/bluetooth_rx_sync.sv
// bt_sync: two-flop synchronizer for the asynchronous RXD pin, reset to the
// idle-high level. With BT_RX_GLITCH_FILTER_EN defined it also keeps a
// 3-deep history of the synchronized line (the newest entry being the
// synchronizer output itself) and offers the majority vote of it as the
// value to sample; otherwise the vote output is the synchronized line.
module bt_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic vote
);

    logic meta;

    // Two-stage synchronizer; both stages reset to the idle line level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta <= 1'b1;
            sync <= 1'b1;
        end else begin
            meta <= din;
            sync <= meta;
        end
    end

`ifdef BT_RX_GLITCH_FILTER_EN
    // Older two entries of the history; entry 0 is the synchronizer output.
    logic [2:1] hist;

    // Shift the synchronized line into the history every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hist <= 2'b11;
        end else begin
            hist <= {hist[1], sync};
        end
    end

    assign vote = (sync & hist[1]) | (sync & hist[2]) | (hist[1] & hist[2]);
`else
    assign vote = sync;
`endif

endmodule

// File: rtl/bluetooth_rx.sv
// bluetooth_rx: 8N1 receiver for the Bluetooth module's TX line.
// Start edge is detected on the synchronized line, the start bit is
// re-checked at mid-bit, then data and stop bits are sampled one bit period
// apart. Good frames update data with a one-cycle valid; a low stop bit
// gives a one-cycle frame_err and parks in BREAK until the line goes high.
// Optional feature macro: BT_RX_GLITCH_FILTER_EN (majority-vote sampling,
// implemented inside bt_sync; sample timing is the same either way).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | line idle, waiting for a low level on the synchronized line
// ST_START | timing half a bit to re-check the start bit
// ST_DATA  | sampling 8 data bits, LSB first, one bit period apart
// ST_STOP  | waiting one bit period to sample the stop bit
// ST_BREAK | stop bit was low; wait for the line to return high
module bluetooth_rx
    import bt_pkg::*;
#(
    parameter int BAUD_DIV = BT_BAUD_DIV_9600,
    parameter int HALF_DIV = BAUD_DIV / 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           RXD,
    bluetooth_rx_if.master rx
);

    localparam int              DATA_BITS = BT_FRAME_BITS - 2;
    localparam int              CW        = $clog2(BAUD_DIV);
    localparam logic [CW-1:0]   BAUD_LAST = CW'(BAUD_DIV - 1);
    localparam logic [CW-1:0]   HALF_LAST = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0]   CNT_ONE   = CW'(1);
    localparam logic [2:0]      LAST_BIT  = 3'(DATA_BITS - 1);

    logic                   rxd_s;
    logic                   rxd_v;
    bt_rx_state_t           state;
    logic [CW-1:0]          cnt;
    logic [2:0]             bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic [DATA_BITS-1:0]   data_q;
    logic                   valid_q;
    logic                   ferr_q;
    logic                   busy_q;

    bt_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (RXD),
        .sync  (rxd_s),
        .vote  (rxd_v)
    );

    // Receive FSM; all outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!rxd_s) begin
                        state  <= ST_START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxd_v) begin
                            state   <= ST_DATA;
                            bit_idx <= '0;
                        end else begin
                            // High at mid-start: a glitch, not a frame.
                            state  <= ST_IDLE;
                            busy_q <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt == BAUD_LAST) begin
                        cnt            <= '0;
                        shreg[bit_idx] <= rxd_v;
                        bit_idx        <= bit_idx + 3'd1;
                        if (bit_idx == LAST_BIT) begin
                            state <= ST_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_STOP: begin
                    if (cnt == BAUD_LAST) begin
                        cnt <= '0;
                        if (rxd_v) begin
                            data_q  <= shreg;
                            valid_q <= 1'b1;
                            state   <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            ferr_q <= 1'b1;
                            state  <= ST_BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                ST_BREAK: begin
                    if (rxd_s) begin
                        state  <= ST_IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= ST_IDLE;
                    cnt    <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign rx.data      = data_q;
    assign rx.valid     = valid_q;
    assign rx.frame_err = ferr_q;
    assign rx.busy      = busy_q;

endmodule
